// File: rtl/pc_gen.sv
// Registered fetch PC generator with a fetch handshake, a one-entry redirect buffer
// for stalled cycles, and alignment filtering of non-exception redirect targets.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0200,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      io_pc_sel,
  input  logic [XLEN-1:0] io_pc_jalr,
  input  logic [XLEN-1:0] io_pc_br,
  input  logic [XLEN-1:0] io_pc_jmp,
  input  logic [XLEN-1:0] io_pc_excp,
  input  logic            io_if_ready,
  output logic [XLEN-1:0] io_pc,
  output logic            io_pc_valid,
  output logic            io_pend_valid,
  output logic            io_misalign,
  output logic [XLEN-1:0] io_misalign_addr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_exc_q, pend_exc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            is_redir, is_exc, low_bad, drop, accept, fire;
  logic [XLEN-1:0] tgt;

  // Reserved selects fall through to sequential.
  always_comb begin
    is_redir = 1'b0;
    is_exc   = 1'b0;
    tgt      = '0;
    case (io_pc_sel)
      3'd1: begin is_redir = 1'b1; tgt = io_pc_jalr; end
      3'd2: begin is_redir = 1'b1; tgt = io_pc_br;   end
      3'd3: begin is_redir = 1'b1; tgt = io_pc_jmp;  end
      3'd4: begin is_redir = 1'b1; is_exc = 1'b1; tgt = io_pc_excp; end
      default: ;
    endcase
  end

  assign low_bad = (IALIGN == 4) ? (tgt[1:0] != 2'b00) : tgt[0];
  assign drop    = is_redir & ~is_exc & low_bad;
  assign accept  = is_redir & ~drop;
  assign fire    = valid_q & io_if_ready;

  always_comb begin
    valid_d         = 1'b1;
    pc_d            = pc_q;
    pend_valid_d    = pend_valid_q;
    pend_exc_d      = pend_exc_q;
    pend_pc_d       = pend_pc_q;
    misalign_d      = drop;
    misalign_addr_d = drop ? tgt : misalign_addr_q;
    if (fire) begin
      if (accept && is_exc) begin
        pc_d = tgt;
      end else if (pend_valid_q && pend_exc_q) begin
        pc_d = pend_pc_q;
      end else if (accept) begin
        pc_d = tgt;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = pc_q + XLEN'(INC);
      end
      pend_valid_d = 1'b0;
      pend_exc_d   = 1'b0;
    end else if (accept && (is_exc || !pend_exc_q)) begin
      // A buffered exception is only displaced by a newer exception.
      pend_valid_d = 1'b1;
      pend_exc_d   = is_exc;
      pend_pc_d    = tgt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q         <= 1'b0;
      pc_q            <= RESET_VECTOR;
      pend_valid_q    <= 1'b0;
      pend_exc_q      <= 1'b0;
      pend_pc_q       <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      pend_valid_q    <= pend_valid_d;
      pend_exc_q      <= pend_exc_d;
      pend_pc_q       <= pend_pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign io_pc            = pc_q;
  assign io_pc_valid      = valid_q;
  assign io_pend_valid    = pend_valid_q;
  assign io_misalign      = misalign_q;
  assign io_misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: IALIGN=4 and IALIGN=2 instances share stimulus and are each
// compared against a behavioural model, plus directed scenarios with fixed expectations.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sel;
  logic [31:0] jalr, br, jmp, excp;
  logic        ready;

  logic [31:0] pc4, maddr4, pc2, maddr2;
  logic        val4, pend4, mis4, val2, pend2, mis2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pv;
    logic        pe;
    logic [31:0] pp;
    logic        mis;
    logic [31:0] maddr;
  } m_t;

  m_t m4, m2;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h200), .INC(4), .IALIGN(4)) u_dut4 (
    .clk(clk), .reset(reset), .io_pc_sel(sel), .io_pc_jalr(jalr), .io_pc_br(br),
    .io_pc_jmp(jmp), .io_pc_excp(excp), .io_if_ready(ready), .io_pc(pc4),
    .io_pc_valid(val4), .io_pend_valid(pend4), .io_misalign(mis4),
    .io_misalign_addr(maddr4)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h200), .INC(4), .IALIGN(2)) u_dut2 (
    .clk(clk), .reset(reset), .io_pc_sel(sel), .io_pc_jalr(jalr), .io_pc_br(br),
    .io_pc_jmp(jmp), .io_pc_excp(excp), .io_if_ready(ready), .io_pc(pc2),
    .io_pc_valid(val2), .io_pend_valid(pend2), .io_misalign(mis2),
    .io_misalign_addr(maddr2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic m_t model_reset();
    m_t r;
    r.pc = 32'h200; r.valid = 1'b0; r.pv = 1'b0; r.pe = 1'b0; r.pp = '0;
    r.mis = 1'b0; r.maddr = '0;
    return r;
  endfunction

  // One clock edge of the fetch PC rules, for alignment granule ia bytes.
  function automatic m_t model_next(input m_t s, input int unsigned ia);
    m_t          n = s;
    logic [31:0] t = '0;
    bit          redir = 1'b1;
    bit          exc = 1'b0;
    bit          bad;
    bit          fire = s.valid && ready;
    case (sel)
      3'd1: t = jalr;
      3'd2: t = br;
      3'd3: t = jmp;
      3'd4: begin t = excp; exc = 1'b1; end
      default: redir = 1'b0;
    endcase
    bad = redir && !exc && (t % ia != 0);
    if (bad) redir = 1'b0;
    n.mis = bad;
    if (bad) n.maddr = t;
    n.valid = 1'b1;
    if (fire) begin
      if (redir && exc)         n.pc = t;
      else if (s.pv && s.pe)    n.pc = s.pp;
      else if (redir)           n.pc = t;
      else if (s.pv)            n.pc = s.pp;
      else                      n.pc = s.pc + 32'd4;
      n.pv = 1'b0;
      n.pe = 1'b0;
    end else if (redir && (exc || !(s.pv && s.pe))) begin
      n.pv = 1'b1;
      n.pe = exc;
      n.pp = t;
    end
    return n;
  endfunction

  task automatic compare_all();
    check_eq("pc4",    pc4,    m4.pc);
    check_eq("valid4", {31'd0, val4},  {31'd0, m4.valid});
    check_eq("pend4",  {31'd0, pend4}, {31'd0, m4.pv});
    check_eq("mis4",   {31'd0, mis4},  {31'd0, m4.mis});
    check_eq("maddr4", maddr4, m4.maddr);
    check_eq("pc2",    pc2,    m2.pc);
    check_eq("valid2", {31'd0, val2},  {31'd0, m2.valid});
    check_eq("pend2",  {31'd0, pend2}, {31'd0, m2.pv});
    check_eq("mis2",   {31'd0, mis2},  {31'd0, m2.mis});
    check_eq("maddr2", maddr2, m2.maddr);
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] t, input logic r);
    sel = s; jalr = t; br = t; jmp = t; excp = t; ready = r;
  endtask

  // Called at a negedge with inputs set; advances one edge and checks.
  task automatic tick();
    m4 = model_next(m4, 4);
    m2 = model_next(m2, 2);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1'b1;
    drive(3'd0, 32'h0, 1'b1);
    m4 = model_reset();
    m2 = model_reset();
    #1;
    compare_all();
    check_eq("rst_pc", pc4, 32'h200);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rel_valid", {31'd0, val4}, 32'd0);

    // Startup sequence.
    tick(); check_eq("seq0", pc4, 32'h200);
    tick(); check_eq("seq1", pc4, 32'h204);
    tick(); check_eq("seq2", pc4, 32'h208);
    tick(); check_eq("seq3", pc4, 32'h20C);

    // Branch with and without stall.
    drive(3'd3, 32'h300, 1'b1);  tick();
    drive(3'd2, 32'h1000, 1'b1); tick();
    check_eq("br_fire", pc4, 32'h1000);
    check_eq("br_nopend", {31'd0, pend4}, 32'd0);
    drive(3'd3, 32'h300, 1'b1);  tick();
    drive(3'd2, 32'h1000, 1'b0); tick();
    check_eq("br_hold", pc4, 32'h300);
    check_eq("br_pend", {31'd0, pend4}, 32'd1);
    drive(3'd0, 32'h0, 1'b1);    tick();
    check_eq("br_late", pc4, 32'h1000);

    // Buffered exception outranks later non-exception redirects.
    drive(3'd3, 32'h2000, 1'b0); tick();
    drive(3'd4, 32'h80, 1'b0);   tick();
    drive(3'd1, 32'h3000, 1'b0); tick();
    drive(3'd0, 32'h0, 1'b1);    tick();
    check_eq("excp_win", pc4, 32'h80);

    // Misaligned jalr: dropped for IALIGN=4, taken for IALIGN=2.
    drive(3'd1, 32'h1002, 1'b1); tick();
    check_eq("mis_pc4", pc4, 32'h84);
    check_eq("mis_pulse", {31'd0, mis4}, 32'd1);
    check_eq("mis_addr", maddr4, 32'h1002);
    check_eq("ia2_pc", pc2, 32'h1002);
    drive(3'd0, 32'h0, 1'b1);    tick();
    check_eq("mis_end", {31'd0, mis4}, 32'd0);

    // Wrap and reserved select.
    drive(3'd3, 32'hFFFF_FFFC, 1'b1); tick();
    drive(3'd0, 32'h0, 1'b1);         tick();
    check_eq("wrap", pc4, 32'h0);
    drive(3'd6, 32'h5000, 1'b1);      tick();
    check_eq("sel6", pc4, 32'h4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      else if ($urandom_range(0, 1) != 0) t[0] = 1'b0;
      sel   = 3'($urandom_range(0, 7));
      jalr  = t;
      br    = t ^ 32'h0000_1000;
      jmp   = {t[31:2], 2'b00};
      excp  = t + 32'h40;
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Asynchronous reset while a redirect is pending.
    drive(3'd3, 32'h4000, 1'b0); tick();
    check_eq("pre_rst_pend", {31'd0, pend4}, 32'd1);
    #2;
    reset = 1'b1;
    m4 = model_reset();
    m2 = model_reset();
    #1;
    check_eq("async_pc", pc4, 32'h200);
    check_eq("async_pend", {31'd0, pend4}, 32'd0);
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    drive(3'd0, 32'h0, 1'b1);
    tick(); tick();
    check_eq("post_rst", pc4, 32'h204);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
